// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, stage payload widths and
// the occupancy encoding used by the inter-stage registers.
package pipe_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;
  localparam int CTRL_W   = 10;

  // Payload widths of the four inter-stage registers
  localparam int IFID_DATA_W  = 2 * XLEN;             // pc, instruction
  localparam int IDEX_DATA_W  = 4 * XLEN + XLEN;      // pc, rs1, rs2, imm, reg ids
  localparam int EXMEM_DATA_W = 3 * XLEN;             // alu result, store data, reg ids
  localparam int MEMWB_DATA_W = 3 * XLEN;             // load data, alu result, reg ids

  // Control bundle bit positions
  localparam int CTL_MEMTOREG = 0;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMWRITE = 2;
  localparam int CTL_REGWRITE = 3;
  localparam int CTL_BRANCH   = 4;
  localparam int CTL_ALUSRC   = 5;
  localparam int CTL_ALUOP_LO = 6;
  localparam int CTL_ALUOP_HI = 7;

  // Number of entries held by a stage register
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // True when a control bundle would update architectural state downstream
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTL_MEMWRITE] | ctrl[CTL_REGWRITE];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage register: valid flag, payload and
// control bundle. Clearing an entry zeroes its control so a bubble can never
// trigger a write; the payload is left untouched on clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CTRL_W-1:0] ctrl_r;

  // Entry storage: clear wins over load, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= d_data;
      ctrl_r  <= d_ctrl;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
      ctrl_r  <= ctrl_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign ctrl  = ctrl_r;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register. With SKID=1 a second entry
// absorbs the beat arriving during a stall so that in_ready comes straight
// from a flop; with SKID=0 a single entry is used and in_ready looks through
// to out_ready. Flush kills every held and incoming beat on the next edge.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  logic              acc_s;
  logic              pop_s;
  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic              main_load_s;
  logic              main_clear_s;
  occ_e              occ_r;
  occ_e              occ_next_s;

  assign acc_s = in_valid & in_ready;
  assign pop_s = main_valid_s & out_ready;

  generate
    if (SKID) begin : g_skid
      logic              skid_valid_s;
      logic [DATA_W-1:0] skid_data_s;
      logic [CTRL_W-1:0] skid_ctrl_s;
      logic              skid_load_s;
      logic              skid_clear_s;
      logic [DATA_W-1:0] main_src_data_s;
      logic [CTRL_W-1:0] main_src_ctrl_s;

      // A held skid beat is always the older one, so it refills main first
      assign in_ready        = ~skid_valid_s;
      assign main_src_data_s = skid_valid_s ? skid_data_s : in_data;
      assign main_src_ctrl_s = skid_valid_s ? skid_ctrl_s : in_ctrl;

      // Slot load/clear decisions and next occupancy for the two-entry stage
      always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        occ_next_s   = occ_r;
        if (flush) begin
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
          occ_next_s   = OCC_EMPTY;
        end else begin
          case (occ_r)
            OCC_EMPTY: begin
              if (acc_s) begin
                main_load_s = 1'b1;
                occ_next_s  = OCC_ONE;
              end else begin
                occ_next_s  = OCC_EMPTY;
              end
            end
            OCC_ONE: begin
              if (pop_s && acc_s) begin
                main_load_s  = 1'b1;
                occ_next_s   = OCC_ONE;
              end else if (pop_s) begin
                main_clear_s = 1'b1;
                occ_next_s   = OCC_EMPTY;
              end else if (acc_s) begin
                skid_load_s  = 1'b1;
                occ_next_s   = OCC_FULL;
              end else begin
                occ_next_s   = OCC_ONE;
              end
            end
            OCC_FULL: begin
              if (pop_s) begin
                main_load_s  = 1'b1;
                skid_clear_s = 1'b1;
                occ_next_s   = OCC_ONE;
              end else begin
                occ_next_s   = OCC_FULL;
              end
            end
            default: begin
              main_clear_s = 1'b1;
              skid_clear_s = 1'b1;
              occ_next_s   = OCC_EMPTY;
            end
          endcase
        end
      end

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load_s),
        .clear  (main_clear_s),
        .d_data (main_src_data_s),
        .d_ctrl (main_src_ctrl_s),
        .valid  (main_valid_s),
        .data   (main_data_s),
        .ctrl   (main_ctrl_s)
      );

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load_s),
        .clear  (skid_clear_s),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_valid_s),
        .data   (skid_data_s),
        .ctrl   (skid_ctrl_s)
      );
    end else begin : g_single
      // A full entry can still accept when it is being drained this cycle
      assign in_ready = ~main_valid_s | out_ready;

      // Slot load/clear decisions and next occupancy for the single-entry stage
      always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        occ_next_s   = occ_r;
        if (flush) begin
          main_clear_s = 1'b1;
          occ_next_s   = OCC_EMPTY;
        end else if (acc_s) begin
          main_load_s  = 1'b1;
          occ_next_s   = OCC_ONE;
        end else if (pop_s) begin
          main_clear_s = 1'b1;
          occ_next_s   = OCC_EMPTY;
        end else begin
          occ_next_s   = occ_r;
        end
      end

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load_s),
        .clear  (main_clear_s),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (main_valid_s),
        .data   (main_data_s),
        .ctrl   (main_ctrl_s)
      );
    end
  endgenerate

  // Occupancy state, mirrors the number of valid slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= OCC_EMPTY;
    end else begin
      occ_r <= occ_next_s;
    end
  end

  assign out_valid = main_valid_s;
  assign out_data  = main_data_s;
  assign out_ctrl  = main_ctrl_s;
  assign occ       = occ_r;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and randomised checks of pipe_stage_hs, one instance per SKID value.
module tb_pipe_stage_hs;

  localparam int DW = 16;
  localparam int CW = 10;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occ;
    logic          ir;
  } vec_t;

  logic clk;
  logic rst;

  logic          a_flush, a_iv, a_ir, a_ov, a_ordy;
  logic [DW-1:0] a_id, a_od;
  logic [CW-1:0] a_ic, a_oc;
  logic [1:0]    a_occ;
  logic          b_flush, b_iv, b_ir, b_ov, b_ordy;
  logic [DW-1:0] b_id, b_od;
  logic [CW-1:0] b_ic, b_oc;
  logic [1:0]    b_occ;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_ctrl(a_ic), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_ctrl(a_oc), .occ(a_occ)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_ctrl(b_ic), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_ctrl(b_oc), .occ(b_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] id,
                              input logic [CW-1:0] ic, input logic ordy, input logic ov,
                              input logic [DW-1:0] od, input logic [CW-1:0] oc,
                              input logic [1:0] occ, input logic ir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input vec_t v);
    if (w == 0) begin
      a_flush = v.fl; a_iv = v.iv; a_id = v.id; a_ic = v.ic; a_ordy = v.ordy;
    end else begin
      b_flush = v.fl; b_iv = v.iv; b_id = v.id; b_ic = v.ic; b_ordy = v.ordy;
    end
  endtask

  task automatic sample(input int w, output logic ov, output logic [DW-1:0] od,
                        output logic [CW-1:0] oc, output logic [1:0] occv, output logic ir);
    if (w == 0) begin
      ov = a_ov; od = a_od; oc = a_oc; occv = a_occ; ir = a_ir;
    end else begin
      ov = b_ov; od = b_od; oc = b_oc; occv = b_occ; ir = b_ir;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tab_a[16];
  vec_t tab_b[7];
  vec_t idle;

  logic [DW+CW-1:0] m[2][2];
  int               mn[2];

  initial begin
    logic          ov, ir, exp_ir, acc, pop;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occv;
    vec_t          rv[2];
    string         nm;

    //                fl    iv    data      ctrl      ordy   ov    data      ctrl      occ   ir
    tab_a[0]  = mk(1'b0, 1'b1, 16'h0011, 10'h011, 1'b1, 1'b1, 16'h0011, 10'h011, 2'd1, 1'b1);
    tab_a[1]  = mk(1'b0, 1'b1, 16'h0022, 10'h022, 1'b1, 1'b1, 16'h0022, 10'h022, 2'd1, 1'b1);
    tab_a[2]  = mk(1'b0, 1'b1, 16'h0033, 10'h033, 1'b1, 1'b1, 16'h0033, 10'h033, 2'd1, 1'b1);
    tab_a[3]  = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_a[4]  = mk(1'b0, 1'b1, 16'h00A1, 10'h0A1, 1'b0, 1'b1, 16'h00A1, 10'h0A1, 2'd1, 1'b1);
    tab_a[5]  = mk(1'b0, 1'b1, 16'h00A2, 10'h0A2, 1'b0, 1'b1, 16'h00A1, 10'h0A1, 2'd2, 1'b0);
    tab_a[6]  = mk(1'b0, 1'b1, 16'h00A3, 10'h0A3, 1'b0, 1'b1, 16'h00A1, 10'h0A1, 2'd2, 1'b0);
    tab_a[7]  = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b1, 16'h00A2, 10'h0A2, 2'd1, 1'b1);
    tab_a[8]  = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_a[9]  = mk(1'b0, 1'b1, 16'h00B1, 10'h0B1, 1'b0, 1'b1, 16'h00B1, 10'h0B1, 2'd1, 1'b1);
    tab_a[10] = mk(1'b0, 1'b1, 16'h00B2, 10'h0B2, 1'b0, 1'b1, 16'h00B1, 10'h0B1, 2'd2, 1'b0);
    tab_a[11] = mk(1'b1, 1'b1, 16'h00B3, 10'h0B3, 1'b0, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_a[12] = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_a[13] = mk(1'b0, 1'b1, 16'h00D1, 10'h0D1, 1'b0, 1'b1, 16'h00D1, 10'h0D1, 2'd1, 1'b1);
    tab_a[14] = mk(1'b1, 1'b1, 16'h00D2, 10'h0D2, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_a[15] = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);

    tab_b[0]  = mk(1'b0, 1'b1, 16'h00C1, 10'h0C1, 1'b0, 1'b1, 16'h00C1, 10'h0C1, 2'd1, 1'b0);
    tab_b[1]  = mk(1'b0, 1'b1, 16'h00C2, 10'h0C2, 1'b1, 1'b1, 16'h00C2, 10'h0C2, 2'd1, 1'b1);
    tab_b[2]  = mk(1'b0, 1'b1, 16'h00C3, 10'h0C3, 1'b0, 1'b1, 16'h00C2, 10'h0C2, 2'd1, 1'b0);
    tab_b[3]  = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_b[4]  = mk(1'b0, 1'b1, 16'h00C4, 10'h0C4, 1'b0, 1'b1, 16'h00C4, 10'h0C4, 2'd1, 1'b0);
    tab_b[5]  = mk(1'b1, 1'b1, 16'h00C5, 10'h0C5, 1'b0, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);
    tab_b[6]  = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);

    idle = mk(1'b0, 1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 16'h0000, 10'h000, 2'd0, 1'b1);

    // Reset held with a beat offered: nothing may be captured
    rst = 1'b0;
    drive(0, mk(1'b0, 1'b1, 16'h5A5A, 10'h3FF, 1'b1, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    drive(1, mk(1'b0, 1'b1, 16'hA5A5, 10'h3FF, 1'b1, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w, ov, od, oc, occv, ir);
      chk($sformatf("rst%0d.out_valid", w), 32'(ov), 32'd0);
      chk($sformatf("rst%0d.out_ctrl", w), 32'(oc), 32'd0);
      chk($sformatf("rst%0d.out_data", w), 32'(od), 32'd0);
      chk($sformatf("rst%0d.occ", w), 32'(occv), 32'd0);
      chk($sformatf("rst%0d.in_ready", w), 32'(ir), 32'd1);
    end
    rst = 1'b1;
    drive(0, idle);
    drive(1, idle);
    repeat (2) tick();
    for (int w = 0; w < 2; w++) begin
      sample(w, ov, od, oc, occv, ir);
      chk($sformatf("post_rst%0d.out_valid", w), 32'(ov), 32'd0);
    end

    // Table A: SKID=1 streaming, stall/skid and flush
    for (int i = 0; i < 16; i++) begin
      drive(0, tab_a[i]);
      tick();
      sample(0, ov, od, oc, occv, ir);
      chk($sformatf("tabA[%0d].out_valid", i), 32'(ov), 32'(tab_a[i].ov));
      chk($sformatf("tabA[%0d].out_ctrl", i), 32'(oc), 32'(tab_a[i].oc));
      chk($sformatf("tabA[%0d].occ", i), 32'(occv), 32'(tab_a[i].occ));
      chk($sformatf("tabA[%0d].in_ready", i), 32'(ir), 32'(tab_a[i].ir));
      if (tab_a[i].ov) chk($sformatf("tabA[%0d].out_data", i), 32'(od), 32'(tab_a[i].od));
    end

    // Table B: SKID=0 pass-through and flush
    drive(0, idle);
    for (int i = 0; i < 7; i++) begin
      drive(1, tab_b[i]);
      tick();
      sample(1, ov, od, oc, occv, ir);
      chk($sformatf("tabB[%0d].out_valid", i), 32'(ov), 32'(tab_b[i].ov));
      chk($sformatf("tabB[%0d].out_ctrl", i), 32'(oc), 32'(tab_b[i].oc));
      chk($sformatf("tabB[%0d].occ", i), 32'(occv), 32'(tab_b[i].occ));
      chk($sformatf("tabB[%0d].in_ready", i), 32'(ir), 32'(tab_b[i].ir));
      if (tab_b[i].ov) chk($sformatf("tabB[%0d].out_data", i), 32'(od), 32'(tab_b[i].od));
    end
    drive(1, idle);

    // SKID=1: in_ready stays low while full even when out_ready rises
    drive(0, mk(1'b0, 1'b1, 16'h00E1, 10'h0E1, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    tick();
    drive(0, mk(1'b0, 1'b1, 16'h00E2, 10'h0E2, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    tick();
    drive(0, idle);
    #1;
    chk("skid_full.in_ready_pre_edge", 32'(a_ir), 32'd0);
    tick();
    chk("skid_drain1.out_data", 32'(a_od), 32'h00E2);
    chk("skid_drain1.occ", 32'(a_occ), 32'd1);
    tick();
    chk("skid_drain2.out_valid", 32'(a_ov), 32'd0);

    // SKID=0: full entry accepts in the same cycle it is drained
    drive(1, mk(1'b0, 1'b1, 16'h00F1, 10'h0F1, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    tick();
    drive(1, mk(1'b0, 1'b1, 16'h00F2, 10'h0F2, 1'b1, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    #1;
    chk("single_pass.in_ready_same_cycle", 32'(b_ir), 32'd1);
    tick();
    chk("single_pass.out_data", 32'(b_od), 32'h00F2);
    chk("single_pass.occ", 32'(b_occ), 32'd1);
    drive(1, idle);
    tick();
    chk("single_pass_drain.out_valid", 32'(b_ov), 32'd0);

    // Reset in the middle of a transfer drops everything immediately
    drive(0, mk(1'b0, 1'b1, 16'h0071, 10'h071, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    drive(1, mk(1'b0, 1'b1, 16'h0073, 10'h073, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    tick();
    drive(0, mk(1'b0, 1'b1, 16'h0072, 10'h072, 1'b0, 1'b0, 16'h0, 10'h0, 2'd0, 1'b0));
    drive(1, idle);
    b_ordy = 1'b0;
    tick();
    drive(0, idle);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.a_in_ready", 32'(a_ir), 32'd1);
    chk("midrst.a_out_valid", 32'(a_ov), 32'd0);
    chk("midrst.a_occ", 32'(a_occ), 32'd0);
    chk("midrst.a_out_ctrl", 32'(a_oc), 32'd0);
    chk("midrst.b_out_valid", 32'(b_ov), 32'd0);
    chk("midrst.b_occ", 32'(b_occ), 32'd0);
    drive(1, idle);
    tick();
    rst = 1'b1;
    tick();

    // Random traffic against a reference model on both instances
    mn[0] = 0;
    mn[1] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int w = 0; w < 2; w++) begin
        rv[w] = mk(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                   16'($urandom), 10'($urandom),
                   1'($urandom_range(0, 99) < ((cyc < 5000) ? 70 : 35)),
                   1'b0, 16'h0, 10'h0, 2'd0, 1'b0);
        drive(w, rv[w]);
      end
      #1;
      for (int w = 0; w < 2; w++) begin
        exp_ir = (w == 0) ? (mn[w] < 2) : ((mn[w] == 0) || rv[w].ordy);
        sample(w, ov, od, oc, occv, ir);
        nm = $sformatf("rnd%0d[%0d]", w, cyc);
        chk({nm, ".in_ready"}, 32'(ir), 32'(exp_ir));
        if (rv[w].fl) begin
          mn[w] = 0;
        end else begin
          acc = rv[w].iv & exp_ir;
          pop = (mn[w] > 0) && rv[w].ordy;
          if (pop) begin
            m[w][0] = m[w][1];
            mn[w]--;
          end
          if (acc) begin
            m[w][mn[w]] = {rv[w].ic, rv[w].id};
            mn[w]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
        sample(w, ov, od, oc, occv, ir);
        nm = $sformatf("rnd%0d[%0d]", w, cyc);
        chk({nm, ".out_valid"}, 32'(ov), 32'(mn[w] > 0));
        chk({nm, ".occ"}, 32'(occv), 32'(mn[w]));
        if (mn[w] > 0) begin
          chk({nm, ".out_data"}, 32'(od), 32'(m[w][0][DW-1:0]));
          chk({nm, ".out_ctrl"}, 32'(oc), 32'(m[w][0][DW+CW-1:DW]));
        end else begin
          chk({nm, ".bubble_ctrl"}, 32'(oc), 32'd0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
